// File: rtl/fetch_pc_gen_if.sv
// fetch_pc_gen_if
// ---------------
// Groups the signals that pass between the D-stage control, CP0 and the
// fetch PC generator into one bundle.
//
//   master (D stage / CP0 / hazard side):
//     drives  stall, exc_req, eret, epc, d_pc, d_imm, npc_op, rs_val, rt_val
//     sees    f_pc, f_adel, d_bd, d_taken, d_link
//   slave (fetch_pc_gen):
//     the same signals with the directions reversed
interface fetch_pc_gen_if;
    logic        stall;
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] d_pc;
    logic [25:0] d_imm;
    logic [3:0]  npc_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] f_pc;
    logic        f_adel;
    logic        d_bd;
    logic        d_taken;
    logic [31:0] d_link;

    modport master (
        output stall, exc_req, eret, epc, d_pc, d_imm, npc_op, rs_val, rt_val,
        input  f_pc, f_adel, d_bd, d_taken, d_link
    );

    modport slave (
        input  stall, exc_req, eret, epc, d_pc, d_imm, npc_op, rs_val, rt_val,
        output f_pc, f_adel, d_bd, d_taken, d_link
    );
endinterface

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen
// ------------
// Next-PC generator that owns the F-stage PC register. Resolves the D-stage
// branch or jump from raw forwarded operands, applies exception entry, eret
// and stall, and registers the new fetch PC. Also registers a flag marking
// the instruction entering D as a branch delay slot, and flags fetch
// address errors for CP0.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; f_pc <= RESET_PC, d_bd <= 0
//   bus    fetch_pc_gen_if.slave
//            in : stall, exc_req, eret, epc, d_pc, d_imm, npc_op,
//                 rs_val, rt_val
//            out: f_pc (reg), d_bd (reg), f_adel, d_taken, d_link (comb)
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IM_SIZE  = 32'h0000_4000
) (
    input  logic           clk,
    input  logic           reset,
    fetch_pc_gen_if.slave  bus
);

    localparam logic [3:0] OP_NORMAL = 4'd0;
    localparam logic [3:0] OP_BEQ    = 4'd1;
    localparam logic [3:0] OP_BNE    = 4'd2;
    localparam logic [3:0] OP_BLEZ   = 4'd3;
    localparam logic [3:0] OP_BGTZ   = 4'd4;
    localparam logic [3:0] OP_BLTZ   = 4'd5;
    localparam logic [3:0] OP_BGEZ   = 4'd6;
    localparam logic [3:0] OP_J      = 4'd7;
    localparam logic [3:0] OP_JR     = 4'd8;

    // The end of the legal fetch window is held in 33 bits so that a window
    // reaching the top of the address space does not wrap to zero.
    localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + {1'b0, IM_SIZE};

    logic [31:0] fPc_q, fPc_d;
    logic        dBd_q, dBd_d;

    logic [31:0] pcPlus4;
    logic [31:0] brOffset;
    logic [31:0] brTgt;
    logic [31:0] jTgt;
    logic        rsEqRt;
    logic        rsNeg;
    logic        rsZero;
    logic        isCtrl;
    logic        taken;
    logic [31:0] takenTgt;

    // Candidate targets. The branch offset is a sign-extended word offset
    // from the delay slot; the jump keeps the delay slot's top nibble.
    assign pcPlus4  = bus.d_pc + 32'd4;
    assign brOffset = {{14{bus.d_imm[15]}}, bus.d_imm[15:0], 2'b00};
    assign brTgt    = pcPlus4 + brOffset;
    assign jTgt     = {pcPlus4[31:28], bus.d_imm, 2'b00};

    // Signed compares against zero reduce to the sign bit and a zero test.
    assign rsEqRt = (bus.rs_val == bus.rt_val);
    assign rsNeg  = bus.rs_val[31];
    assign rsZero = (bus.rs_val == 32'd0);

    // Any real branch or jump puts the following instruction in a delay
    // slot, whether or not it is taken.
    assign isCtrl = (bus.npc_op >= OP_BEQ) && (bus.npc_op <= OP_JR);

    // Branch resolution: decides whether D redirects fetch and where to.
    // Reserved opcodes fall through to the not-taken default.
    always_comb begin
        taken    = 1'b0;
        takenTgt = brTgt;
        case (bus.npc_op)
            OP_BEQ:  taken = rsEqRt;
            OP_BNE:  taken = !rsEqRt;
            OP_BLEZ: taken = rsNeg || rsZero;
            OP_BGTZ: taken = !rsNeg && !rsZero;
            OP_BLTZ: taken = rsNeg;
            OP_BGEZ: taken = !rsNeg;
            OP_J: begin
                taken    = 1'b1;
                takenTgt = jTgt;
            end
            OP_JR: begin
                taken    = 1'b1;
                takenTgt = bus.rs_val;
            end
            default: taken = 1'b0;
        endcase
    end

    // Next-state selection for the fetch PC and delay-slot flag. Exception
    // entry beats eret, and both override a stall so a trap is never lost
    // behind a hazard.
    always_comb begin
        fPc_d = fPc_q + 32'd4;
        dBd_d = isCtrl;
        if (bus.exc_req) begin
            fPc_d = EXC_PC;
            dBd_d = 1'b0;
        end else if (bus.eret) begin
            fPc_d = bus.epc;
            dBd_d = 1'b0;
        end else if (bus.stall) begin
            fPc_d = fPc_q;
            dBd_d = dBd_q;
        end else if (taken) begin
            fPc_d = takenTgt;
        end
    end

    // F-stage state; reset takes priority over every redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            fPc_q <= RESET_PC;
            dBd_q <= 1'b0;
        end else begin
            fPc_q <= fPc_d;
            dBd_q <= dBd_d;
        end
    end

    assign bus.f_pc    = fPc_q;
    assign bus.d_bd    = dBd_q;
    assign bus.d_taken = taken;
    assign bus.d_link  = bus.d_pc + 32'd8;
    assign bus.f_adel  = (fPc_q[1:0] != 2'b00)
                       || (fPc_q < IM_BASE)
                       || ({1'b0, fPc_q} >= IM_LIMIT);

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen
// ---------------
// Self-checking bench for fetch_pc_gen. Each vector drives one cycle of
// inputs; the combinational outputs are compared in-cycle and the expected
// registered state is queued and compared after the next rising edge.
module tb_fetch_pc_gen;

    logic clk;
    logic reset;

    fetch_pc_gen_if bus ();

    fetch_pc_gen dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        exc;
        logic        eret;
        logic [31:0] epc;
        logic [31:0] dPc;
        logic [25:0] dImm;
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        expTaken;
        logic [31:0] expPc;
        logic        expBd;
        logic        expAdel;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        bd;
        logic        adel;
        int          idx;
    } exp_t;

    exp_t scoreboard[$];
    vec_t vecs[$];
    int   assertCount = 0;
    int   failCount   = 0;

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so a broken design can never hang the run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(
        input logic rst, input logic stall, input logic exc, input logic eret,
        input logic [31:0] epc, input logic [31:0] dPc, input logic [25:0] dImm,
        input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
        input logic expTaken, input logic [31:0] expPc, input logic expBd,
        input logic expAdel);
        vec_t v;
        v.rst = rst;   v.stall = stall; v.exc = exc;   v.eret = eret;
        v.epc = epc;   v.dPc = dPc;     v.dImm = dImm; v.op = op;
        v.rs = rs;     v.rt = rt;
        v.expTaken = expTaken; v.expPc = expPc;
        v.expBd = expBd;       v.expAdel = expAdel;
        return v;
    endfunction

    task automatic check32(input string name, input int idx,
                           input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s (vec %0d): got %h, expected %h", name, idx, act, exp);
        end
    endtask

    // Pops one expected registered state, if any is pending, and compares it.
    task automatic checkOutput();
        exp_t e;
        if (scoreboard.size() == 0) return;
        e = scoreboard.pop_front();
        check32("f_pc",   e.idx, bus.f_pc, e.pc);
        check32("d_bd",   e.idx, {31'd0, bus.d_bd}, {31'd0, e.bd});
        check32("f_adel", e.idx, {31'd0, bus.f_adel}, {31'd0, e.adel});
    endtask

    // Drives one cycle of inputs at the falling edge, checks the
    // combinational outputs, and queues the post-edge expectation.
    task automatic applyStimulus(input vec_t v, input int idx);
        exp_t e;
        @(negedge clk);
        checkOutput();
        reset       = v.rst;
        bus.stall   = v.stall;
        bus.exc_req = v.exc;
        bus.eret    = v.eret;
        bus.epc     = v.epc;
        bus.d_pc    = v.dPc;
        bus.d_imm   = v.dImm;
        bus.npc_op  = v.op;
        bus.rs_val  = v.rs;
        bus.rt_val  = v.rt;
        #1;
        check32("d_taken", idx, {31'd0, bus.d_taken}, {31'd0, v.expTaken});
        check32("d_link",  idx, bus.d_link, v.dPc + 32'd8);
        e.pc   = v.expPc;
        e.bd   = v.expBd;
        e.adel = v.expAdel;
        e.idx  = idx;
        scoreboard.push_back(e);
    endtask

    initial begin
        reset       = 1'b1;
        bus.stall   = 1'b0;
        bus.exc_req = 1'b0;
        bus.eret    = 1'b0;
        bus.epc     = 32'd0;
        bus.d_pc    = 32'd0;
        bus.d_imm   = 26'd0;
        bus.npc_op  = 4'd0;
        bus.rs_val  = 32'd0;
        bus.rt_val  = 32'd0;

        //             rst stl exc ert epc           d_pc          d_imm        op    rs            rt          tkn exp_pc        bd adel
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        32'h0,        26'h0,       4'd0, 32'h0,        32'h0,       0, 32'h0000_3000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        26'h0,       4'd0, 32'h0,        32'h0,       0, 32'h0000_3004, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        26'h0,       4'd0, 32'h0,        32'h0,       0, 32'h0000_3008, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        26'h0,       4'd0, 32'h0,        32'h0,       0, 32'h0000_300C, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0000_3004, 26'h000FFFE, 4'd1, 32'd5,        32'd5,       1, 32'h0000_3000, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0000_3004, 26'h000FFFE, 4'd1, 32'd5,        32'd6,       0, 32'h0000_3004, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        26'h0,       4'd0, 32'h0,        32'h0,       0, 32'h0000_3008, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0000_3008, 26'h0000010, 4'd5, 32'h8000_0000, 32'h0,       1, 32'h0000_304C, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0000_3010, 26'h0000010, 4'd4, 32'h0,        32'h0,       0, 32'h0000_3050, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0000_3010, 26'h0000004, 4'd6, 32'h0,        32'h0,       1, 32'h0000_3024, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0000_3020, 26'h0000008, 4'd3, 32'hFFFF_FFFF, 32'h0,       1, 32'h0000_3044, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0000_3040, 26'h0000002, 4'd2, 32'd1,        32'd2,       1, 32'h0000_304C, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0000_3FFC, 26'h0000C10, 4'd7, 32'h0,        32'h0,       1, 32'h0000_3040, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0000_3040, 26'h0,       4'd8, 32'h0000_3002, 32'h0,       1, 32'h0000_3002, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0000_3040, 26'h0,       4'd8, 32'h0000_7000, 32'h0,       1, 32'h0000_7000, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0000_3040, 26'h0,       4'd9, 32'h0,        32'h0,       0, 32'h0000_7004, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0000_3040, 26'h0,       4'd8, 32'h0000_3100, 32'h0,       1, 32'h0000_3100, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,        32'h0000_3100, 26'h000FFFE, 4'd1, 32'd1,        32'd1,       1, 32'h0000_3100, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,        32'h0000_3100, 26'h000FFFE, 4'd1, 32'd1,        32'd1,       1, 32'h0000_4180, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 32'h0000_3010, 32'h0,        26'h0,       4'd0, 32'h0,        32'h0,       0, 32'h0000_4180, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 32'h0000_3010, 32'h0000_3FFC, 26'h0000C10, 4'd7, 32'h0,        32'h0,       1, 32'h0000_3010, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0000_3010, 26'h0000C40, 4'd7, 32'h0,        32'h0,       1, 32'h0000_3100, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,        32'h0,        26'h0,       4'd0, 32'h0,        32'h0,       0, 32'h0000_3100, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 32'h0,        32'h0,        26'h0,       4'd0, 32'h0,        32'h0,       0, 32'h0000_3000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        26'h0,       4'd0, 32'h0,        32'h0,       0, 32'h0000_3004, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'hFFFF_FFF8, 26'h0000004, 4'd2, 32'd0,        32'd1,       1, 32'h0000_000C, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'hF000_0000, 26'h0000C00, 4'd7, 32'h0,        32'h0,       1, 32'hF000_3000, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        26'h0,       4'd0, 32'h0,        32'h0,       0, 32'hF000_3004, 0, 1));

        foreach (vecs[i]) applyStimulus(vecs[i], i);

        // Reset mid-stream, then a branch held by a three-cycle stall that
        // must take effect only once the stall drops.
        applyStimulus(mk(1, 0, 0, 1, 32'h0000_5000, 32'h0, 26'h0, 4'd8, 32'h0000_6000, 32'h0, 1, 32'h0000_3000, 0, 0), 100);
        for (int k = 0; k < 3; k++)
            applyStimulus(mk(0, 1, 0, 0, 32'h0, 32'h0000_3000, 26'h0000003, 4'd1, 32'd9, 32'd9, 1, 32'h0000_3000, 0, 0), 101 + k);
        applyStimulus(mk(0, 0, 0, 0, 32'h0, 32'h0000_3000, 26'h0000003, 4'd1, 32'd9, 32'd9, 1, 32'h0000_3010, 1, 0), 104);
        applyStimulus(mk(0, 1, 0, 0, 32'h0, 32'h0, 26'h0, 4'd0, 32'h0, 32'h0, 0, 32'h0000_3010, 1, 0), 105);
        applyStimulus(mk(0, 0, 0, 0, 32'h0, 32'h0, 26'h0, 4'd0, 32'h0, 32'h0, 0, 32'h0000_3014, 0, 0), 106);

        @(negedge clk);
        checkOutput();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Parametrised next-PC generator that also owns the F-stage PC register. It sits between the D stage and instruction memory. Each cycle it resolves D-stage branches and jumps from raw operand values, applies stall, exception-entry and eret redirects, and updates the fetch PC. It also produces a registered branch-delay flag for the instruction entering D and a fetch address-error flag for CP0.

## Interface
- RESET_PC, 32'h0000_3000, fetch address after reset
- EXC_PC, 32'h0000_4180, exception handler entry address
- IM_BASE, 32'h0000_3000, lowest legal fetch address
- IM_SIZE, 32'h0000_4000, bytes of legal fetch space starting at IM_BASE
- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-high
- stall  in  1  hold F and D (from hazard unit)
- exc_req  in  1  take exception; redirect to EXC_PC
- eret  in  1  return from exception; redirect to epc
- epc  in  32  return address from CP0
- d_pc  in  32  PC of instruction in D
- d_imm  in  26  instr[25:0] of instruction in D
- npc_op  in  4  D-stage control: 0 NORMAL, 1 BEQ, 2 BNE, 3 BLEZ, 4 BGTZ, 5 BLTZ, 6 BGEZ, 7 J, 8 JR; 9–15 are treated as NORMAL
- rs_val  in  32  forwarded rs value
- rt_val  in  32  forwarded rt value
- f_pc  out  32  registered fetch PC
- f_adel  out  1  fetch address error for f_pc
- d_bd  out  1  registered flag: the instruction now in D is a branch delay slot
- d_taken  out  1  the D-stage branch/jump redirects (combinational)
- d_link  out  32  d_pc + 8, the link value for jal/jalr

## Operation
- Comparisons are signed two's complement over 32 bits.
  - BEQ/BNE compare rs_val with rt_val.
  - BLEZ/BGTZ/BLTZ/BGEZ compare rs_val with 0.
- br_tgt = d_pc + 4 + {sext(d_imm[15:0]), 2'b00}, computed mod 2^32 (wraps, no error).
- j_tgt = {(d_pc+4)[31:28], d_imm, 2'b00}.
- jr target = rs_val, passed unmodified. A misaligned target raises f_adel only after it is fetched.
- d_taken = 1 for J and JR, and for conditional ops whose condition holds. It is 0 for NORMAL and reserved codes.
- next_pc priority, highest first:
  - reset → RESET_PC
  - exc_req → EXC_PC
  - eret → epc
  - stall → f_pc (hold)
  - d_taken → the taken target
  - otherwise → f_pc + 4 (mod 2^32)
- d_bd update, same priority order:
  - reset, exc_req or eret → 0
  - stall → hold
  - otherwise → 1 iff npc_op ∈ {1..8}, whether or not the branch is taken (the F instruction moving into D is a delay slot).
- f_adel = (f_pc[1:0] != 0) | (f_pc < IM_BASE) | (f_pc >= IM_BASE+IM_SIZE). Compute the bound in 33 bits so IM_BASE+IM_SIZE = 2^32 does not wrap.

## Timing
- f_pc and d_bd are registers updated on the rising clk edge. All other outputs are combinational from current inputs and registers.
- Reset values: f_pc = RESET_PC, d_bd = 0. f_adel is then derived (0 with the default parameters).
- Redirect latency: a taken D-stage branch in cycle t gives f_pc = target in cycle t+1. The delay-slot instruction (fetched in cycle t) is not squashed.
- exc_req or eret asserted in cycle t: f_pc = EXC_PC / epc in t+1, regardless of stall or npc_op.
- If exc_req and eret are both high, exc_req wins.
- stall high with no redirect: f_pc and d_bd are unchanged. d_taken may still read 1 but has no effect.
- reset asserted mid-stream wins over every other input in the same cycle.

## Test plan
- Reset, then 3 unstalled NORMAL cycles → f_pc = 0x3000, 0x3004, 0x3008, 0x300C; d_bd = 0; f_adel = 0.
- d_pc = 0x3004, BEQ, rs = rt = 5, d_imm[15:0] = 0xFFFE → d_taken = 1, next f_pc = 0x3000, d_bd = 1 the following cycle. Repeat with rt = 6 → f_pc + 4, d_bd still 1.
- Signed compares: BLTZ with rs = 0x8000_0000 is taken. BGTZ with rs = 0 is not taken. BGEZ with rs = 0 is taken. BLEZ with rs = 0xFFFF_FFFF is taken.
- J with d_pc = 0x0000_3FFC, d_imm = 0x0000_C10 → f_pc = 0x0000_3040.
- JR rs = 0x3002 → next f_pc = 0x3002, f_adel = 1. JR rs = 0x7000 → f_adel = 1 (out of range with default bounds).
- Stall with BEQ taken → f_pc held, d_bd held. Same cycle with exc_req = 1 → f_pc = 0x4180, d_bd = 0. exc_req and eret (epc = 0x3010) together → 0x4180. eret alone → 0x3010. Reset together with exc_req → 0x3000.
